snake_stepper: RTL and testbench
================================

Name: snake_stepper

Overview:
Consumer end of the game-tick pulse. Buffers player direction requests between ticks and advances the snake head one grid cell on every accepted tick, with wrap-around at the playfield edges. Sits between the button debouncers/tick generator and the body/render logic, all in the clk_pix domain. Emits a 1-cycle step pulse that downstream body-shift and collision logic uses to stay in lock-step.

Parameters:
GRID_W, 40, playfield width in cells (2..2^X_W)
GRID_H, 30, playfield height in cells (2..2^Y_W)
X_W, 6, head_x width
Y_W, 5, head_y width
START_X, 20, head_x after reset (< GRID_W)
START_Y, 15, head_y after reset (< GRID_H)
START_DIR, 1, dir_cur after reset (0=up, 1=right, 2=down, 3=left)

Ports:
clk  in  1  pixel clock (clk_pix)
rst_n  in  1  asynchronous active-low reset
tick  in  1  1-cycle step strobe from the tick generator
run  in  1  1 = game running; 0 = paused, ticks ignored
dir_valid  in  1  1-cycle direction request strobe
dir_req  in  2  requested direction (encoding as START_DIR)
head_x  out  X_W  current head column
head_y  out  Y_W  current head row
dir_cur  out  2  direction of the most recent move
step  out  1  1-cycle pulse: head moved this cycle
wrapped  out  1  1-cycle pulse, coincident with step: the move crossed an edge
q_full  out  1  request queue holds 2 entries

Behaviour:
- Reset (async assert, sync release): head_x=START_X, head_y=START_Y, dir_cur=START_DIR, step=0, wrapped=0, queue empty, q_full=0, state=PAUSED.
- States: PAUSED and RUNNING. In PAUSED, if run=1 go to RUNNING at the next edge. In RUNNING, if run=0 go to PAUSED at the next edge. A tick is accepted only in RUNNING with run=1 sampled on the same edge. All other ticks are dropped and not remembered.
- Request queue: 2-entry FIFO. The reference direction is the queue tail if the queue is non-empty, otherwise dir_cur.
- A request is accepted only when all of these hold: dir_valid=1, queue not full, dir_req != reference, and dir_req != reference XOR 2 (no 180° reversal).
- Rejected requests are silently dropped. Requests are accepted in both states.
- Accepted tick, on the sampling edge:
  - If the queue is non-empty, pop the head entry into dir_cur. The move uses that new direction.
  - Otherwise the move uses the existing dir_cur.
- Move arithmetic:
  - up: y-1.
  - down: y+1.
  - left: x-1.
  - right: x+1.
  - Wrap: x=0 moving left gives GRID_W-1; x=GRID_W-1 moving right gives 0. Same rule for y with GRID_H.
  - All arithmetic is done at the field width. No out-of-range value is ever output.
- Outputs are registered. head_x, head_y, dir_cur, step and wrapped update on the edge that samples tick=1, so step is high exactly the cycle after the tick cycle. Latency from tick to new head is 1 cycle.
- Simultaneous tick and dir_valid on the same edge:
  - The pop happens first.
  - The request is checked against the post-pop reference (tail if one entry remains, else the newly popped dir_cur).
  - If the queue was full, the pop frees a slot and the request may be accepted on that edge.
- q_full is the registered occupancy==2 flag, valid the same cycle as the occupancy.
- Reset asserted mid-game returns every output to its reset value immediately, without waiting for a clock edge.

Test Plan:
1. Reset, run=1, start direction right at (20,15), 3 ticks spaced 10 cycles apart -> head_x 21,22,23; head_y=15; step high for 1 cycle exactly 1 cycle after each tick; wrapped=0.
2. head at x=39 moving right, 1 tick -> head_x=0, wrapped=1 for 1 cycle; repeat at x=0 moving left -> head_x=39, wrapped=1.
3. dir_cur=right, request left -> dropped; request right -> dropped; request up -> queued; next tick -> dir_cur=up, head_y decremented by 1.
4. Between ticks request up then left, then a third request down -> first two queued, q_full=1, third dropped; next tick moves up; following tick moves left; queue ends empty.
5. Queue full, then tick and dir_valid(down, valid after the pop) on the same edge -> pop and move happen, request accepted, occupancy stays 2, q_full stays 1.
6. run=0 while ticks keep arriving -> no step pulses and head unchanged. Assert rst_n low between edges mid-game -> outputs return to (20,15,right) asynchronously, queue empty.

Source files
------------

// File: rtl/snake_stepper.sv
// Snake head stepper: buffers up to two direction requests between game ticks and
// advances the head one cell per accepted tick, wrapping at the playfield edges.
module snake_stepper #(
  parameter int unsigned GRID_W    = 40,
  parameter int unsigned GRID_H    = 30,
  parameter int unsigned X_W       = 6,
  parameter int unsigned Y_W       = 5,
  parameter int unsigned START_X   = 20,
  parameter int unsigned START_Y   = 15,
  parameter int unsigned START_DIR = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           run,
  input  logic           dir_valid,
  input  logic [1:0]     dir_req,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [1:0]     dir_cur,
  output logic           step,
  output logic           wrapped,
  output logic           q_full,
  output logic           dbg_state
);

  typedef enum logic {S_PAUSED = 1'b0, S_RUNNING = 1'b1} state_e;

  localparam logic [1:0]     DIR_UP    = 2'd0;
  localparam logic [1:0]     DIR_RIGHT = 2'd1;
  localparam logic [1:0]     DIR_DOWN  = 2'd2;
  localparam logic [1:0]     DIR_LEFT  = 2'd3;
  localparam logic [X_W-1:0] X_MAX     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX     = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0] X_START   = X_W'(START_X);
  localparam logic [Y_W-1:0] Y_START   = Y_W'(START_Y);
  localparam logic [1:0]     D_START   = 2'(START_DIR);

  state_e         state_q;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [1:0]     dir_q;
  logic           step_q, wrap_q, wrap_d, q_full_q;
  // Request FIFO: q0 is the oldest entry, q1 the second; cnt is occupancy 0..2.
  logic [1:0]     q0_q, q1_q, q0_d, q1_d;
  logic [1:0]     cnt_q, cnt_d;

  logic           tick_acc, pop, push;
  logic [1:0]     dir_mv, cnt_ap, q0_ap, ref_dir;

  always_comb begin
    tick_acc = (state_q == S_RUNNING) && run && tick;
    pop      = tick_acc && (cnt_q != 2'd0);
    dir_mv   = pop ? q0_q : dir_q;
    cnt_ap   = cnt_q - {1'b0, pop};
    q0_ap    = pop ? q1_q : q0_q;

    // Requests are judged against the queue as it stands after this edge's pop.
    case (cnt_ap)
      2'd2:    ref_dir = q1_q;
      2'd1:    ref_dir = q0_ap;
      default: ref_dir = dir_mv;
    endcase

    push = dir_valid && (cnt_ap != 2'd2) && (dir_req != ref_dir)
           && (dir_req != (ref_dir ^ 2'd2));

    q0_d = q0_ap;
    q1_d = q1_q;
    if (push) begin
      if (cnt_ap == 2'd0) q0_d = dir_req;
      else                q1_d = dir_req;
    end
    cnt_d = cnt_ap + {1'b0, push};

    x_d    = x_q;
    y_d    = y_q;
    wrap_d = 1'b0;
    case (dir_mv)
      DIR_UP: begin
        wrap_d = (y_q == '0);
        y_d    = wrap_d ? Y_MAX : y_q - 1'b1;
      end
      DIR_DOWN: begin
        wrap_d = (y_q == Y_MAX);
        y_d    = wrap_d ? '0 : y_q + 1'b1;
      end
      DIR_LEFT: begin
        wrap_d = (x_q == '0);
        x_d    = wrap_d ? X_MAX : x_q - 1'b1;
      end
      default: begin
        wrap_d = (x_q == X_MAX);
        x_d    = wrap_d ? '0 : x_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_PAUSED;
      x_q      <= X_START;
      y_q      <= Y_START;
      dir_q    <= D_START;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      q0_q     <= DIR_UP;
      q1_q     <= DIR_UP;
      cnt_q    <= 2'd0;
      q_full_q <= 1'b0;
    end else begin
      case (state_q)
        S_PAUSED:  if (run)  state_q <= S_RUNNING;
        S_RUNNING: if (!run) state_q <= S_PAUSED;
        default:             state_q <= S_PAUSED;
      endcase

      q0_q     <= q0_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      q_full_q <= (cnt_d == 2'd2);
      step_q   <= tick_acc;
      wrap_q   <= tick_acc && wrap_d;
      if (tick_acc) begin
        x_q   <= x_d;
        y_q   <= y_d;
        dir_q <= dir_mv;
      end
    end
  end

  assign head_x    = x_q;
  assign head_y    = y_q;
  assign dir_cur   = dir_q;
  assign step      = step_q;
  assign wrapped   = wrap_q;
  assign q_full    = q_full_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_snake_stepper.sv
// Directed bench for snake_stepper: each issued tick pushes its expected move into a
// queue; a negedge monitor pops and checks whenever step is presented.
module tb_snake_stepper;

  localparam int W = 14;  // {x[5:0], y[4:0], dir[1:0], wrap}

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       run = 1'b0;
  logic       dir_valid = 1'b0;
  logic [1:0] dir_req = 2'd0;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [1:0] dir_cur;
  logic       step, wrapped, q_full, dbg_state;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;

  snake_stepper dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run),
    .dir_valid(dir_valid), .dir_req(dir_req),
    .head_x(head_x), .head_y(head_y), .dir_cur(dir_cur),
    .step(step), .wrapped(wrapped), .q_full(q_full), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n && wrapped === 1'b1 && step !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL wrapped_without_step: got wrapped=1 step=%0d expected step=1", step);
    end
    if (rst_n && step === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_step: got step=1 at cycle %0d expected none", cyc);
      end else begin
        logic [W-1:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if ({head_x, head_y, dir_cur, wrapped} !== e || cyc != ec) begin
          n_err++;
          $display("FAIL step_move: got x=%0d y=%0d dir=%0d wrap=%0d cyc=%0d expected x=%0d y=%0d dir=%0d wrap=%0d cyc=%0d",
                   head_x, head_y, dir_cur, wrapped, cyc,
                   e[13:8], e[7:3], e[2:1], e[0], ec);
        end
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int x, input int y, input int d, input int w);
    logic [5:0] xx;
    logic [4:0] yy;
    logic [1:0] dd;
    xx = 6'(x);
    yy = 5'(y);
    dd = 2'(d);
    exp_q.push_back({xx, yy, dd, w[0]});
    exp_cyc_q.push_back(cyc + 1);
  endtask

  task automatic do_tick(input int x, input int y, input int d, input int w);
    @(negedge clk);
    tick = 1'b1;
    push_exp(x, y, d, w);
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic tick_req(input logic [1:0] r, input int x, input int y, input int d, input int w);
    @(negedge clk);
    tick = 1'b1;
    dir_valid = 1'b1;
    dir_req = r;
    push_exp(x, y, d, w);
    @(negedge clk);
    tick = 1'b0;
    dir_valid = 1'b0;
  endtask

  task automatic drop_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic req(input logic [1:0] r);
    @(negedge clk);
    dir_valid = 1'b1;
    dir_req = r;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  initial begin
    int guard;
    // Reset values
    #12;
    chk("rst_x", 32'(head_x), 20);
    chk("rst_y", 32'(head_y), 15);
    chk("rst_dir", 32'(dir_cur), 1);
    chk("rst_step", 32'(step), 0);
    chk("rst_wrapped", 32'(wrapped), 0);
    chk("rst_q_full", 32'(q_full), 0);
    chk("rst_state", 32'(dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    run = 1'b1;
    idle(1);
    chk("state_running", 32'(dbg_state), 1);

    // Three spaced ticks moving right
    do_tick(21, 15, 1, 0);
    idle(8);
    do_tick(22, 15, 1, 0);
    idle(8);
    do_tick(23, 15, 1, 0);
    idle(8);

    // Run to the right edge, wrap to 0, then wrap at x=0 going left
    for (int i = 0; i < 16; i++) do_tick(24 + i, 15, 1, 0);
    do_tick(0, 15, 1, 1);
    req(2'd0);
    req(2'd3);
    chk("q_full_two", 32'(q_full), 1);
    do_tick(0, 14, 0, 0);
    do_tick(39, 14, 3, 1);
    chk("q_empty_after_wrap", 32'(q_full), 0);

    // Reversal and same-direction requests are dropped
    req(2'd1);
    req(2'd3);
    chk("q_after_drops", 32'(q_full), 0);
    req(2'd0);
    do_tick(39, 13, 0, 0);

    // Two queued, third dropped while full
    req(2'd3);
    req(2'd2);
    chk("q_full_set", 32'(q_full), 1);
    req(2'd1);
    chk("q_full_hold", 32'(q_full), 1);
    do_tick(38, 13, 3, 0);
    do_tick(38, 14, 2, 0);
    chk("q_full_clear", 32'(q_full), 0);
    do_tick(38, 15, 2, 0);

    // Full queue, tick and request on the same edge: pop frees a slot
    req(2'd3);
    req(2'd0);
    chk("q_full_pre_sim", 32'(q_full), 1);
    tick_req(2'd1, 37, 15, 3, 0);
    chk("q_full_post_sim", 32'(q_full), 1);
    do_tick(37, 14, 0, 0);
    do_tick(38, 14, 1, 0);
    chk("q_full_drained", 32'(q_full), 0);

    // Paused: ticks ignored, requests still taken
    @(negedge clk);
    run = 1'b0;
    idle(1);
    chk("state_paused", 32'(dbg_state), 0);
    drop_tick();
    drop_tick();
    drop_tick();
    req(2'd2);
    chk("paused_x", 32'(head_x), 38);
    chk("paused_y", 32'(head_y), 14);
    // run rises with a tick on the same edge: still PAUSED there, tick dropped
    @(negedge clk);
    run = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    do_tick(38, 15, 2, 0);

    // Asynchronous reset mid-game with a request pending
    req(2'd3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_x", 32'(head_x), 20);
    chk("arst_y", 32'(head_y), 15);
    chk("arst_dir", 32'(dir_cur), 1);
    chk("arst_q_full", 32'(q_full), 0);
    chk("arst_state", 32'(dbg_state), 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    do_tick(21, 15, 1, 0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    idle(2);
    chk("pending_moves", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
